// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - register offsets inside the 8-byte window
//   - STATUS bit positions
//   - serializer state encoding
package uart_tx_pkg;

  localparam logic [2:0] UART_TXDATA_OFS = 3'h0;
  localparam logic [2:0] UART_STATUS_OFS = 3'h4;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   push, wdata     write request and data; ignored when full unless pop is also set
//   pop             read request; ignored when empty
//   rdata           head entry, valid whenever empty = 0
//   count           number of stored entries (0..DEPTH)
//   full, empty     occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // When full, the head is read out combinationally before the edge, so the
  // slot it frees can take the incoming word on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data port.
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   d_addr       core data address; window selected by [31:3], register by [2]
//   d_wdata      core store data
//   d_wstrb      byte strobes; only bit 0 has an effect
//   d_sel        combinational window hit
//   d_rdata      combinational read data (STATUS, else 0)
//   tx           registered serial line, idle high
// Bus handshake: there is none. A store takes effect on the edge where it is
// presented with d_wstrb[0] = 1; reads are combinational with no wait state.
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_sel,
  output logic [31:0] d_rdata,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          overflow;

  logic          sel_status;
  logic          push_req;
  logic          push_ok;
  logic          ovf_clr;
  logic          pop;
  logic          baud_last;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{d_addr[1:0], d_wdata[31:8], d_wstrb[3:1]};

  // Address decode
  assign d_sel      = (d_addr[31:3] == BASE_ADDR[31:3]);
  assign sel_status = (d_addr[2] == UART_STATUS_OFS[2]);
  assign push_req   = d_sel && !sel_status && d_wstrb[0];
  assign ovf_clr    = d_sel && sel_status && d_wstrb[0] && d_wdata[STAT_OVF_BIT];

  // The serializer pops only from IDLE, so a pop frees a slot on the same edge.
  assign pop     = (state == IDLE) && !fifo_empty;
  assign push_ok = push_req && (!fifo_full || pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .wdata (d_wdata[7:0]),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset)                      overflow <= 1'b0;
    else if (push_req && !push_ok)  overflow <= 1'b1;
    else if (ovf_clr)               overflow <= 1'b0;
  end

  always_comb begin
    status = '0;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_BUSY_BIT]  = (state != IDLE);
    status[STAT_OVF_BIT]   = overflow;
    status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
  end

  assign d_rdata = (d_sel && sel_status) ? status : 32'h0;

  // Serializer
  assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shreg <= fifo_rdata;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // tx takes the next bit now; the register catches up on the shift.
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 8.
// A transaction-level reference model predicts STATUS and the bytes that go
// out on the line; a line decoder recovers frames from a per-cycle tx log.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          CPB     = 4;
  localparam int          DEPTH   = 8;
  localparam int          FRAME   = 10 * CPB;
  localparam int          SPACING = FRAME + 1;
  localparam int          LOG_MAX = 8192;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [3:0]  d_wstrb = 4'h0;
  logic        d_sel;
  logic [31:0] d_rdata;
  logic        tx;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wstrb (d_wstrb),
    .d_sel   (d_sel),
    .d_rdata (d_rdata),
    .tx      (tx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- tx line log (one sample per cycle) ----------------
  logic tx_log [LOG_MAX];
  int   log_n = 0;

  always @(negedge clk) begin
    if (log_n < LOG_MAX) tx_log[log_n] = tx;
    log_n++;
  end

  // ---------------- reference model ----------------
  // Transaction view: a pop starts a frame that owns the line for FRAME
  // cycles plus one idle cycle, so the next pop is SPACING edges later.
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  int         m_edge = 0;
  int         m_free_at = 0;
  logic       m_ov = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_pop;
  logic       m_hit;

  always @(posedge clk) begin
    m_edge++;
    if (reset) begin
      m_fifo.delete();
      m_ov      = 1'b0;
      m_free_at = 0;
    end else begin
      m_pop = (m_edge >= m_free_at) && (m_fifo.size() != 0);
      if (m_pop) begin
        exp_q.push_back(m_fifo.pop_front());
        m_free_at = m_edge + SPACING;
      end
      m_hit = (d_addr[31:3] == BASE[31:3]);
      if (m_hit && d_addr[2] && d_wstrb[0] && d_wdata[3]) m_ov = 1'b0;
      if (m_hit && !d_addr[2] && d_wstrb[0]) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(d_wdata[7:0]);
        else                       m_ov = 1'b1;
      end
    end
    m_busy = (m_edge < m_free_at - 1);
  end

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    int          n;
    n     = m_fifo.size();
    s     = 32'h0;
    s[0]  = (n == DEPTH);
    s[1]  = (n == 0);
    s[2]  = m_busy;
    s[3]  = m_ov;
    s[11:8] = n[3:0];
    return s;
  endfunction

  // ---------------- line decoder ----------------
  logic [7:0] dec_b[$];
  int         dec_s[$];
  int         bad_stop;

  task automatic decode(input int from, input int to);
    int i;
    logic [7:0] v;
    dec_b.delete();
    dec_s.delete();
    bad_stop = 0;
    i = from;
    while (i + FRAME <= to) begin
      if (tx_log[i] == 1'b0 && tx_log[i-1] == 1'b1) begin
        for (int b = 0; b < 8; b++) v[b] = tx_log[i + CPB * (b + 1) + CPB / 2];
        if (tx_log[i + 9 * CPB + CPB / 2] !== 1'b1) bad_stop++;
        dec_b.push_back(v);
        dec_s.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    d_wstrb = 4'h0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    d_addr  = a;
    d_wdata = w;
    d_wstrb = s;
    @(posedge clk);
    #1;
    d_wstrb = 4'h0;
    d_addr  = BASE + 32'h4;
    d_wdata = $urandom;
  endtask

  task automatic read_status();
    d_wstrb = 4'h0;
    d_addr  = BASE + 32'h4 + 32'($urandom_range(0, 3));
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  int         base_l;
  int         mism;
  logic [7:0] burst [10];
  logic [7:0] b8;
  int         op;

  initial begin
    // Reset
    reset  = 1'b1;
    d_addr = BASE + 32'h4;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    read_status();
    chk("rst_status", d_rdata, 32'h0000_0002);
    chk("rst_status_model", d_rdata, model_status());
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_sel_in", 32'(d_sel), 32'h1);
    d_addr = 32'h0000_0004;
    #1;
    chk("sel_out", 32'(d_sel), 32'h0);
    chk("rdata_out", d_rdata, 32'h0);
    d_addr = BASE + 32'($urandom_range(0, 3));
    #1;
    chk("txdata_read", d_rdata, 32'h0);
    idle(1);

    // Single 0x55 frame: waveform and busy
    exp_q.delete();
    base_l = log_n;
    store(BASE, ($urandom & 32'hFFFF_FF00) | 32'h55, 4'b0001);
    for (int j = 0; j < 41; j++) begin
      idle(1);
      read_status();
      chk("busy_55", 32'(d_rdata[2]), (j < FRAME) ? 32'h1 : 32'h0);
    end
    idle(2);
    mism = 0;
    if (tx_log[base_l + 1] !== 1'b1) mism++;
    for (int k = 0; k < FRAME; k++)
      if (tx_log[base_l + 2 + k] !== frame_bit(8'h55, k / CPB)) mism++;
    if (tx_log[base_l + 2 + FRAME] !== 1'b1) mism++;
    chk("wave_55", 32'(mism), 32'h0);
    decode(base_l, log_n);
    chk("frames_55", 32'(dec_b.size()), 32'h1);
    chk("byte_55", 32'(dec_b[0]), 32'h55);
    chk("byte_55_model", 32'(dec_b[0]), 32'(exp_q[0]));

    // Store with strobe bit 0 clear: no push
    base_l = log_n;
    store(BASE, ($urandom & 32'hFFFF_FF00) | 32'hA3, 4'b1110);
    read_status();
    chk("nopush_status", d_rdata, 32'h0000_0002);
    chk("nopush_model", d_rdata, model_status());
    idle(12);
    mism = 0;
    for (int k = base_l; k < log_n; k++) if (tx_log[k] !== 1'b1) mism++;
    chk("nopush_tx_low_cycles", 32'(mism), 32'h0);

    // Two back-to-back frames
    exp_q.delete();
    base_l = log_n;
    store(BASE, 32'h41, 4'b0001);
    store(BASE, 32'h42, 4'b0001);
    idle(2 * SPACING + 10);
    decode(base_l, log_n);
    chk("b2b_frames", 32'(dec_b.size()), 32'h2);
    chk("b2b_byte0", 32'(dec_b[0]), 32'h41);
    chk("b2b_byte1", 32'(dec_b[1]), 32'h42);
    chk("b2b_spacing", 32'(dec_s[1] - dec_s[0]), 32'(SPACING));
    chk("b2b_stop", 32'(bad_stop), 32'h0);

    // Ten-byte burst: overflow, clear, nine frames
    exp_q.delete();
    for (int i = 0; i < 10; i++) burst[i] = 8'($urandom_range(0, 255));
    base_l = log_n;
    for (int i = 0; i < 10; i++)
      store(BASE, {24'($urandom), burst[i]}, {3'($urandom_range(0, 7)), 1'b1});
    read_status();
    chk("burst_status", d_rdata, 32'h0000_080D);
    chk("burst_status_model", d_rdata, model_status());
    store(BASE + 32'h4, 32'h8, 4'b0001);
    read_status();
    chk("ovf_clear_status", d_rdata, 32'h0000_0805);
    chk("ovf_clear_model", d_rdata, model_status());
    idle(9 * SPACING + 10);
    decode(base_l, log_n);
    chk("burst_frames", 32'(dec_b.size()), 32'h9);
    for (int i = 0; i < 9; i++) begin
      chk("burst_byte", 32'(dec_b[i]), 32'(burst[i]));
      chk("burst_byte_model", 32'(dec_b[i]), 32'(exp_q[i]));
    end
    read_status();
    chk("burst_drained", d_rdata, 32'h0000_0002);

    // Reset in the DATA phase of the second of three frames
    for (int i = 0; i < 3; i++) store(BASE, 32'($urandom_range(0, 255)), 4'b0001);
    idle(SPACING + 12);
    read_status();
    chk("pre_reset_busy", 32'(d_rdata[2]), 32'h1);
    reset  = 1'b1;
    base_l = log_n;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_tx", 32'(tx), 32'h1);
    read_status();
    chk("reset_status", d_rdata, 32'h0000_0002);
    chk("reset_status_model", d_rdata, model_status());
    idle(3 * SPACING);
    chk("reset_tx_log", 32'(tx_log[base_l + 1]), 32'h1);
    decode(base_l + 1, log_n);
    chk("reset_no_frames", 32'(dec_b.size()), 32'h0);

    // Randomized traffic checked against the model
    exp_q.delete();
    base_l = log_n;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        b8 = 8'($urandom_range(0, 255));
        store(BASE + 32'($urandom_range(0, 3)), {24'($urandom), b8}, 4'($urandom_range(0, 15)));
      end else if (op == 6) begin
        store(BASE + 32'h4 + 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
      end else if (op == 7) begin
        store(BASE + 32'h8 + 32'($urandom_range(0, 7)), $urandom, 4'hF);
      end else begin
        idle($urandom_range(1, 50));
      end
      read_status();
      chk("rand_status", d_rdata, model_status());
    end
    idle(9 * SPACING + 10);
    decode(base_l, log_n);
    chk("rand_frames", 32'(dec_b.size()), 32'(exp_q.size()));
    chk("rand_stop", 32'(bad_stop), 32'h0);
    for (int i = 0; i < dec_b.size(); i++)
      chk("rand_byte", 32'(dec_b[i]), 32'(exp_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the core's data port, alongside `dmem`; it consumes the core's stores and supplies read data for its own address window. Stores to the TX data register push bytes into an internal FIFO. An 8N1 serializer drains the FIFO onto a single `tx` line. A status register lets software poll for space and detect overflow.

## Interface
- `BASE_ADDR`, 32'h1000_0000: word-aligned base of the 8-byte register window.
- `CLKS_PER_BIT`, 4: clock cycles per UART bit; ≥ 2.
- `FIFO_DEPTH`, 8: byte entries; power of two, ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `d_addr`  in  32: core data address.
- `d_wdata`  in  32: core store data.
- `d_wstrb`  in  4: byte write strobes; all-zero means no write.
- `d_sel`  out  1: combinational; 1 when `d_addr[31:3] == BASE_ADDR[31:3]`. The integrator uses it to steer the read mux and to gate `dmem` writes.
- `d_rdata`  out  32: combinational read data; 0 when `d_sel` = 0.
- `tx`  out  1: serial output, registered, idle high.

## Operation
- Register offsets are decoded from `d_addr[2]`. `d_addr[1:0]` is ignored.
- TXDATA, offset 0x0:
  - A write with `d_wstrb[0]` = 1 pushes `d_wdata[7:0]`. Other strobe bits are ignored.
  - Reads return 0.
- STATUS, offset 0x4, read:
  - bit0 full.
  - bit1 empty.
  - bit2 busy (FSM not IDLE).
  - bit3 overflow (sticky).
  - bits[11:8] FIFO count.
  - All other bits 0.
- STATUS write: when `d_wstrb[0]` = 1 and `d_wdata[3]` = 1, overflow clears. No other STATUS bit is writable.
- Push acceptance:
  - A push is accepted when count < `FIFO_DEPTH`, or when a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow sets.
  - If an overflow set and an overflow clear land on the same edge, the set wins.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE, FIFO non-empty: pop the head into the shift register, go to START, drive `tx` = 0.
  - START: hold for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: shift out 8 bits, LSB first, each held `CLKS_PER_BIT` cycles; a 3-bit bit counter and a baud counter track position.
  - STOP: drive `tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- The baud counter counts 0..`CLKS_PER_BIT`-1 and resets on every state entry.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count is `$clog2(FIFO_DEPTH)+1` bits wide and is zero-extended into STATUS[11:8].

## Timing
- Reset values: `tx` = 1, FSM in IDLE, FIFO empty (count 0), overflow 0.
- Consequently STATUS reads 0x0000_0002 after reset.
- Reset mid-frame aborts the frame immediately. `tx` = 1 on the cycle after the reset edge, and FIFO contents are discarded.
- Push-to-line latency:
  - The push is sampled at edge E0.
  - With the FSM in IDLE, the pop happens at E1 and `tx` falls after E1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from `tx` falling to the end of STOP.
- Between back-to-back frames there is exactly one IDLE cycle with `tx` = 1, so frame-to-frame spacing is 10×`CLKS_PER_BIT`+1.
- STATUS reflects register state before the current edge: a push and a STATUS read in the same cycle show the old count.
- `d_rdata` and `d_sel` have no clocked latency; they are pure functions of `d_addr` and current state.

## Structure
- Package `uart_tx_pkg` holds:
  - offset constants `UART_TXDATA_OFS` = 0, `UART_STATUS_OFS` = 4;
  - STATUS bit-position constants;
  - enum `uart_state_t` {IDLE, START, DATA, STOP}.
- One sub-module, `sync_fifo`:
  - parameters `WIDTH`, `DEPTH`;
  - ports push/pop/wdata/rdata/count/full/empty;
  - first-word-fall-through read data;
  - simultaneous push+pop when full is legal.
- The top level contains the address decode, status mux, overflow flag and serializer FSM.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 8.
- Reset, then read 0x1000_0004 → `d_rdata` = 0x0000_0002, `tx` = 1, `d_sel` = 1. Read 0x0000_0004 → `d_sel` = 0, `d_rdata` = 0.
- Store 0x55 to 0x1000_0000 with `d_wstrb` = 4'b0001 → one cycle after the next edge `tx` runs 0,1,0,1,0,1,0,1,0,1, each level 4 cycles, 40 cycles total; busy = 1 throughout, then `tx` = 1.
- Store 0xA3 with `d_wstrb` = 4'b1110 → no push; count stays 0 and `tx` stays 1.
- Store 0x41, 0x42 on consecutive cycles → two frames with exactly 41 cycles from falling edge to falling edge; decoded bytes are 0x41 then 0x42.
- Push 10 bytes on consecutive cycles:
  - Byte 0 is popped one edge after its push, so bytes 1–8 fill the FIFO and byte 9 is dropped.
  - STATUS then reads full = 1, overflow = 1, count = 8.
  - Writing 0x8 to STATUS clears overflow only.
  - Exactly 9 frames are emitted.
- Assert `reset` during the DATA phase of the second of three queued frames → `tx` = 1 after the reset edge, STATUS = 0x0000_0002, and no further frames are emitted.
